// File: rtl/fir_pkg.sv
// Shared constants, op codes and FSM state type for the 64-tap FIR datapath.
// Used by fir_tap_sequencer, fir_delay_line and the FIR alu.
package fir_pkg;

    localparam int TAPS = 64;
    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int TW   = $clog2(TAPS);

    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: synchronous push at the write pointer, combinational
// read at (base - offset) where base is the slot of the most recent push.
module fir_delay_line
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic [TW-1:0] offset,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [TAPS];
    logic [TW-1:0] wp;
    logic [TW-1:0] base;
    logic [TW-1:0] rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            base <= '0;
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wp] <= wdata;
            base    <= wp;
            wp      <= wp + 1'b1;
        end
    end

    // Pointer arithmetic is TW bits wide, so the subtraction wraps mod TAPS.
    assign rd_idx = base - offset;
    assign rdata  = mem[rd_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences 64 MAC taps into the FIR alu per accepted sample and returns a Q15 result.
// Build option: define FIR_SAT_EN to saturate the Q30->Q15 conversion instead of wrapping.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for an input sample; coefficient writes allowed
// ST_RUN   | issuing taps 0..TAPS-1 to the alu, one per cycle
// ST_DRAIN | alu holds the final sum; convert and register the output
// ST_OUT   | out_valid held until out_ready
module fir_tap_sequencer
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    input  logic          coeff_we,
    input  logic [TW-1:0] coeff_addr,
    input  logic [DW-1:0] coeff_wdata,
    output logic [DW-1:0] alu_coeff,
    output logic [DW-1:0] alu_data,
    output logic [AW-1:0] alu_prev_acc,
    output logic [1:0]    alu_op_code,
    input  logic [AW-1:0] alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sample,
    output logic          busy
);

    fir_state_t    state;
    fir_state_t    state_nxt;
    logic [TW-1:0] tap;
    logic [DW-1:0] coef [TAPS];
    logic [DW-1:0] dl_rdata;
    logic [DW-1:0] q15;
    logic          accept;
    logic          unused_acc_bits;

    assign in_ready     = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign accept       = in_valid && in_ready;
    assign alu_prev_acc = alu_result;

    fir_delay_line u_delay_line (
        .clk    (clk),
        .rst    (rst),
        .push   (accept),
        .wdata  (in_sample),
        .offset (tap),
        .rdata  (dl_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        alu_coeff   = '0;
        alu_data    = '0;
        alu_op_code = OP_RST;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                alu_coeff   = coef[tap];
                alu_data    = dl_rdata;
                alu_op_code = (tap == '0) ? OP_MUL : OP_MAC;
                if (tap == LAST_TAP) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap <= '0;
        end else if (accept) begin
            tap <= '0;
        end else if (state == ST_RUN) begin
            tap <= tap + 1'b1;
        end
    end

    // Only IDLE writes land; a write in the accept cycle is seen from tap 0 on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coeff_we && (state == ST_IDLE)) begin
            coef[coeff_addr] <= coeff_wdata;
        end
    end

    always_comb begin
`ifdef FIR_SAT_EN
        if (alu_result[AW-1] != alu_result[AW-2]) begin
            q15 = alu_result[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            q15 = alu_result[2*DW-2:DW-1];
        end
`else
        q15 = alu_result[2*DW-2:DW-1];
`endif
    end

    assign unused_acc_bits = ^{alu_result[AW-1], alu_result[DW-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else if (state == ST_DRAIN) begin
            out_valid  <= 1'b1;
            out_sample <= q15;
        end else if ((state == ST_OUT) && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer with a behavioural alu and FIR reference model.
// Honours FIR_SAT_EN the same way the design does.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sample;
    logic          coeff_we;
    logic [TW-1:0] coeff_addr;
    logic [DW-1:0] coeff_wdata;
    logic [DW-1:0] alu_coeff;
    logic [DW-1:0] alu_data;
    logic [AW-1:0] alu_prev_acc;
    logic [1:0]    alu_op_code;
    logic [AW-1:0] alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sample;
    logic          busy;

    always #5 clk = ~clk;

    fir_tap_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sample    (in_sample),
        .coeff_we     (coeff_we),
        .coeff_addr   (coeff_addr),
        .coeff_wdata  (coeff_wdata),
        .alu_coeff    (alu_coeff),
        .alu_data     (alu_data),
        .alu_prev_acc (alu_prev_acc),
        .alu_op_code  (alu_op_code),
        .alu_result   (alu_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sample   (out_sample),
        .busy         (busy)
    );

    // Behavioural alu: registered result, one cycle after its operands.
    logic signed [AW-1:0] prod;
    assign prod = $signed(alu_coeff) * $signed(alu_data);

    always_ff @(posedge clk) begin
        case (alu_op_code)
            OP_MUL:  alu_result <= prod;
            OP_MAC:  alu_result <= prod + alu_prev_acc;
            default: alu_result <= '0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] val;
        int            acc_cyc;
    } exp_t;
    exp_t sb[$];

    int vectors    = 0;
    int miscompares = 0;
    bit rdy_rand   = 1'b0;

    logic signed [DW-1:0] coef_m [TAPS];
    logic signed [DW-1:0] hist[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Direct-form FIR sum over the newest-first history, wrapped to 32 bits.
    function automatic logic [DW-1:0] model_out();
        longint acc = 0;
        int     acc32;
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'(coef_m[k]) * longint'(hist[k]);
        end
        acc32 = int'(acc);
`ifdef FIR_SAT_EN
        if (acc32 > 1073741823) return 16'h7FFF;
        if (acc32 < -1073741824) return 16'h8000;
`endif
        return 16'(acc32 >>> 15);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) coef_m[i] = '0;
        hist.delete();
        for (int i = 0; i < TAPS; i++) hist.push_back('0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        coeff_we = 1'b0;
        rst      = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_clear();
        sb.delete();
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_sample", out_sample, 0);
        check("reset alu_op_code", alu_op_code, 0);
    endtask

    task automatic wr_coef(logic [TW-1:0] a, logic [DW-1:0] d);
        coeff_we    = 1'b1;
        coeff_addr  = a;
        coeff_wdata = d;
        coef_m[a]   = d;
        step();
        coeff_we = 1'b0;
    endtask

    task automatic send(logic [DW-1:0] s, bit use_exp, logic [DW-1:0] exp_v,
                        bit cw, logic [TW-1:0] ca, logic [DW-1:0] cd);
        int   n = 0;
        exp_t e;
        while (!in_ready && n < 1000) begin
            step();
            n++;
        end
        if (!in_ready) begin
            check("in_ready timeout", in_ready, 1);
            return;
        end
        in_valid  = 1'b1;
        in_sample = s;
        if (cw) begin
            coeff_we    = 1'b1;
            coeff_addr  = ca;
            coeff_wdata = cd;
            coef_m[ca]  = cd;
        end
        hist.push_front(s);
        void'(hist.pop_back());
        e.val     = use_exp ? exp_v : model_out();
        e.acc_cyc = cyc;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        coeff_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        if (sb.size() != 0) check("drain timeout", sb.size(), 0);
        step();
    endtask

    // Monitor: latency on each out_valid rise, value on each handshake.
    initial begin
        logic prev_ov = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) check("unexpected out_valid", out_valid, 0);
                    else check("out_valid latency", cyc - sb[0].acc_cyc, 66);
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_sample", out_sample, e.val);
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_sample = '0;
        coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0; out_ready = 1'b1;
        model_clear();

        // Single tap, basic scaling and latency.
        do_reset();
        wr_coef(0, 16'h4000);
        send(16'h2000, 1, 16'h1000, 0, 0, 0);
        drain();

        // Impulse of -1.0 through a ramp of coefficients.
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(TW'(k), 16'(k + 1));
        for (int i = 0; i < TAPS; i++)
            send((i == 0) ? 16'h8000 : 16'h0000, 1, 16'(-(i + 1)), 0, 0, 0);
        drain();

        // Accumulator reaches 0x7FFE0002.
        do_reset();
        wr_coef(0, 16'h7FFF);
        wr_coef(1, 16'h7FFF);
        send(16'h7FFF, 0, 0, 0, 0, 0);
`ifdef FIR_SAT_EN
        send(16'h7FFF, 1, 16'h7FFF, 0, 0, 0);
`else
        send(16'h7FFF, 1, 16'hFFFC, 0, 0, 0);
`endif
        drain();

        // Output stall with a competing input presented.
        do_reset();
        wr_coef(0, 16'h4000);
        out_ready = 1'b0;
        send(16'h2000, 1, 16'h1000, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 200) begin step(); n++; end
        in_valid  = 1'b1;
        in_sample = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            check("stall out_valid", out_valid, 1);
            check("stall out_sample", out_sample, 16'h1000);
            check("stall in_ready", in_ready, 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("post-stall in_ready", in_ready, 1);
        check("post-stall out_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            check("post-stall busy", busy, 0);
            step();
        end
        check("stall scoreboard empty", sb.size(), 0);

        // Coefficient write during RUN must be ignored.
        do_reset();
        wr_coef(0, 16'h4000);
        send(16'h2000, 1, 16'h1000, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        coeff_we = 1'b1; coeff_addr = 0; coeff_wdata = 16'h7FFF;
        step();
        coeff_we = 1'b0;
        send(16'h2000, 1, 16'h1000, 0, 0, 0);
        drain();

        // Reset at RUN cycle 30 aborts the sum and clears the delay line.
        do_reset();
        wr_coef(0, 16'h4000);
        send(16'h2000, 1, 16'h1000, 0, 0, 0);
        drain();
        send(16'h2000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 29; i++) step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        model_clear();
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort alu_op_code", alu_op_code, 0);
        check("abort busy", busy, 0);
        wr_coef(0, 16'h4000);
        wr_coef(TW'(TAPS - 1), 16'h4000);
        send(16'h2000, 1, 16'h1000, 0, 0, 0);
        drain();

        // Random coefficients, samples, backpressure and coincident writes.
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(TW'(k), 16'($urandom));
        rdy_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom), 0, 0, ($urandom_range(0, 3) == 0),
                 TW'($urandom_range(0, TAPS - 1)), 16'($urandom));
        end
        drain();
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control and storage stage that sits directly upstream of the FIR `alu` in the 64-tap, 16-bit FIR filter. It accepts one Q15 input sample per handshake and stores it in a 64-entry circular delay line alongside a 64-entry coefficient bank. It then drives the ALU's `coeff`/`data`/`prev_acc`/`op_code` for 64 consecutive cycles and captures the final accumulator. The result is scaled back to a Q15 output sample behind a valid/ready handshake.

## Interface
- `TAPS`, 64: number of taps; must be a power of two.
- `DW`, 16: sample and coefficient width, signed Q15.
- `AW`, 32: accumulator width; must equal the ALU `result` width.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1 / `in_sample` in DW: input sample handshake.
- `coeff_we` in 1 / `coeff_addr` in 6 / `coeff_wdata` in DW: coefficient write port.
- `alu_coeff` out DW / `alu_data` out DW / `alu_prev_acc` out AW / `alu_op_code` out 2: ALU operand outputs.
- `alu_result` in AW: ALU registered result, valid one cycle after its operands.
- `out_valid` out 1 / `out_ready` in 1 / `out_sample` out DW: output handshake.
- `busy` out 1: high in any state other than IDLE.

## Operation
- ALU op codes: 00 = reset (result 0), 01 = multiply (coeff×data), 10 = multiply-accumulate (coeff×data + prev_acc).
- `alu_prev_acc` is wired combinationally to `alu_result`.
- FSM states and transitions:
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DRAIN after tap TAPS−1 is issued.
  - DRAIN → OUT after one cycle.
  - OUT → IDLE on `out_ready`.
- `in_ready` = (state == IDLE).
- On accept, `in_sample` is written to `buf[wp]`, the tap counter is cleared, and `wp` is latched as `base`. `wp` then increments mod TAPS and wraps from 63 to 0.
- In RUN, tap k (k = 0..63) drives:
  - `alu_coeff` = `coef[k]`
  - `alu_data` = `buf[(base − k) mod TAPS]`, so tap 0 is the newest sample.
  - `alu_op_code` = 01 for k = 0, 10 for k ≥ 1.
- Outside RUN, `alu_op_code` = 00 and the operand outputs are 0.
- In DRAIN, `alu_result` is the full sum. It is converted and registered into `out_sample`.
- Output conversion: Q30 → Q15 by taking `acc[30:15]` (truncation, no rounding).
- Accumulator overflow beyond AW wraps inside the ALU. This block does not detect it.
- Coefficient writes take effect only in IDLE; a `coeff_we` pulse in any other state is ignored.
- If a coefficient write and an input accept coincide in IDLE, the write lands first. The new coefficient is used by that sample.
- `out_valid` and `out_sample` hold stable until `out_ready`; a new sample cannot be accepted until then.
- Reset values:
  - state = IDLE, `wp` = 0, all `buf` entries = 0, all `coef` entries = 0.
  - `out_valid` = 0, `out_sample` = 0, `busy` = 0, `alu_op_code` = 00.
  - `in_ready` = 1 in the cycle after reset.
- Reset mid-operation aborts the sum and clears the delay line; no output is produced for the aborted sample.

## Timing
- Accept at cycle 0 → taps issued in cycles 1..64 → DRAIN in cycle 65 → `out_valid` high from cycle 66.
- If `out_ready` is already high in cycle 66: IDLE in cycle 67, `in_ready` high in cycle 67.
- Peak throughput: one sample per 67 cycles.
- `busy` is high from cycle 1 until the OUT handshake completes.

## Configuration
- `FIR_SAT_EN` defined: if `acc[31] != acc[30]`, `out_sample` saturates to 0x7FFF (acc ≥ 0) or 0x8000 (acc < 0). Otherwise `out_sample` = `acc[30:15]`.
- `FIR_SAT_EN` undefined: `out_sample` = `acc[30:15]` unconditionally, with wrap-around.

## Structure
- Shared package `fir_pkg` holds:
  - the op-code constants `OP_RST`/`OP_MUL`/`OP_MAC`;
  - the FSM state enum;
  - the `TAPS`/`DW`/`AW` constants, shared with `alu`.
- Sub-module `fir_delay_line`: circular buffer with synchronous write, combinational read at an offset from `base`, and clear on `rst`.
- The FSM, coefficient bank and output conversion stay at top level.

## Test plan
- Reset; write `coef[0]`=0x4000, all others 0; input 0x2000 → `out_sample` = 0x1000, `out_valid` rises exactly 66 cycles after accept.
- Write `coef[k]` = k+1; feed 0x8000 followed by 63 × 0x0000 → successive outputs are −1, −2, …, −64 (0xFFFF down to 0xFFC0).
- Write `coef[0]` = `coef[1]` = 0x7FFF, others 0; feed 0x7FFF twice (acc = 0x7FFE0002) → second output is 0x7FFF with `FIR_SAT_EN`, 0xFFFC without.
- Hold `out_ready` low for 10 cycles after `out_valid` → `out_sample` stable, `in_ready` low, a presented input is not accepted. Raise `out_ready` → IDLE next cycle and `in_ready` = 1.
- Issue `coeff_we` during RUN (addr 0, data 0x7FFF) → no effect; the next sample still uses the old `coef[0]`.
- Assert `rst` at cycle 30 of RUN → next cycle: IDLE, `out_valid` = 0, `alu_op_code` = 00. Delay line is zero, so a following input 0x2000 with `coef[0]`=0x4000 (all other coefficients 0) yields exactly 0x1000.
